// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the 3x3 convolver control sequencer.
//   - state_t      : sequencer FSM encoding (also driven onto dbg_state)
//   - FLT_TAPS     : taps loaded into the filter shift register at frame start
//   - FILL_EXTRA   : extra cycles after the two line buffers fill before MACs run
//   - MAC_LAT      : pipeline latency of the MAC
//   - MIN_W        : smallest image width the window can slide over
//   - DEF_ADDR_FIFO: default line-buffer address width. The project normally
//                    takes ADDR_FIFO from header.vh; a standalone build
//                    falls back to 10 bits (enough for widths up to 1023).
`ifndef ADDR_FIFO
`define ADDR_FIFO 10
`endif

package conv_pkg;

    localparam int DEF_ADDR_FIFO = `ADDR_FIFO;

    localparam int FLT_TAPS   = 9;
    localparam int FILL_EXTRA = 4;
    localparam int MAC_LAT    = 3;
    localparam int MIN_W      = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_seq_pos_counter.sv
// conv_seq_pos_counter
// Tracks the position (column/row) of the MAC output stream and produces the
// registered out_valid mask. The last two columns of every row are
// wrap-around windows and are masked off.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : next cycle is outside the frame; clear everything
//   i_first        : next cycle carries output index k = 0
//   i_w            : latched image width W
//   o_valid        : registered valid flag for the current output
module conv_seq_pos_counter
    import conv_pkg::*;
#(
    parameter int ADDR_FIFO = DEF_ADDR_FIFO
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_first,
    input  logic [ADDR_FIFO-1:0] i_w,
    output logic                 o_valid
);

    logic [ADDR_FIFO-1:0] r_col;
    logic [ADDR_FIFO-1:0] r_row;
    logic                 r_active;
    logic                 r_valid;

    logic                 w_last_col;
    logic                 w_last;
    logic [ADDR_FIFO-1:0] w_col_nxt;
    logic [ADDR_FIFO-1:0] w_row_nxt;

    always_comb begin
        w_last_col = (r_col == i_w - ADDR_FIFO'(1));
        w_last     = w_last_col && (r_row == i_w - ADDR_FIFO'(1));
        w_col_nxt  = w_last_col ? '0 : r_col + ADDR_FIFO'(1);
        w_row_nxt  = w_last_col ? r_row + ADDR_FIFO'(1) : r_row;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
        end else if (i_flush) begin
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b0;
            r_valid  <= 1'b0;
        end else if (i_first) begin
            r_col    <= '0;
            r_row    <= '0;
            r_active <= 1'b1;
            r_valid  <= (i_w > ADDR_FIFO'(2));
        end else if (r_active) begin
            if (w_last) begin
                // k = W*W-1 was the final output of the frame
                r_active <= 1'b0;
                r_valid  <= 1'b0;
            end else begin
                r_col   <= w_col_nxt;
                r_row   <= w_row_nxt;
                r_valid <= (w_col_nxt < i_w - ADDR_FIFO'(2));
            end
        end
    end

    assign o_valid = r_valid;

endmodule

// File: rtl/conv_sequencer.sv
// conv_sequencer
// Control sequencer for one 3x3 convolver (line buffers + filter shift
// register + MAC). A legal start latches the image width W and runs one
// frame: FILL (2W+4 cycles), RUN (W*W cycles), DRAIN (MAC latency), DONE.
// Every output is registered; next-cycle values are computed from the
// next state and next cycle index, then flopped.
// Handshake: start is a one-cycle command taken only in IDLE; pix_req high
// means upstream must present a pixel in that same cycle (no backpressure);
// abort wins over everything and returns to IDLE on the next edge.
// Ports:
//   clk, rst (async, active-low), start, abort, img_w  : control inputs
//   busy, done, err                                     : status
//   pix_req                                             : upstream pixel strobe
//   shifting_filter, shifting_line, line_buffer_reset,
//   mac_enable, row_length                              : convolver controls
//   out_valid                                           : MAC output is a pixel
//   frame_cycles  (only with CONV_SEQ_PERF_EN)          : accept-to-done cycles
//   dbg_state                                           : FSM state
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_FIFO = DEF_ADDR_FIFO,
    parameter int MAX_W     = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_FIFO-1:0] img_w,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 pix_req,
    output logic                 shifting_filter,
    output logic                 shifting_line,
    output logic                 line_buffer_reset,
    output logic                 mac_enable,
    output logic [ADDR_FIFO-1:0] row_length,
    output logic                 out_valid,
`ifdef CONV_SEQ_PERF_EN
    output logic [31:0]          frame_cycles,
`endif
    output logic [2:0]           dbg_state
);

    localparam int CW = 2 * ADDR_FIFO + 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cyc;
    logic [CW-1:0]        w_cyc_nxt;
    logic [ADDR_FIFO-1:0] r_w;

    logic [CW-1:0] w_w;
    logic [CW-1:0] w_wsq;
    logic [CW-1:0] w_fill_end;
    logic [CW-1:0] w_run_end;
    logic [CW-1:0] w_drain_end;
    logic [CW-1:0] w_win_first;

    logic w_w_legal;
    logic w_accept;
    logic w_busy_nxt;
    logic w_sf_nxt;
    logic w_pix_nxt;
    logic w_sl_nxt;
    logic w_lbr_nxt;
    logic w_mac_nxt;
    logic w_done_nxt;
    logic w_err_nxt;
    logic w_first_out;
    logic w_flush;

    // Frame boundaries, as absolute cycle indices from the accept
    assign w_w         = CW'(r_w);
    assign w_wsq       = w_w * w_w;
    assign w_fill_end  = (w_w << 1) + CW'(FILL_EXTRA - 1);
    assign w_run_end   = w_fill_end + w_wsq;
    assign w_drain_end = w_run_end + CW'(MAC_LAT);
    assign w_win_first = w_fill_end + CW'(MAC_LAT + 1);

    assign w_w_legal = (img_w >= ADDR_FIFO'(MIN_W)) && (img_w <= ADDR_FIFO'(MAX_W));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_w_legal) begin
                        w_state_nxt = S_FILL;
                        w_accept    = 1'b1;
                    end
                end
                S_FILL:  if (r_cyc == w_fill_end)  w_state_nxt = S_RUN;
                S_RUN:   if (r_cyc == w_run_end)   w_state_nxt = S_DRAIN;
                S_DRAIN: if (r_cyc == w_drain_end) w_state_nxt = S_DONE;
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic: values for the next cycle, flopped below
    always_comb begin
        w_busy_nxt  = (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN) ||
                      (w_state_nxt == S_DRAIN);
        w_cyc_nxt   = (w_busy_nxt && !w_accept) ? r_cyc + CW'(1) : '0;
        w_sf_nxt    = w_busy_nxt && (w_cyc_nxt < CW'(FLT_TAPS));
        // r_w is stale on the accept edge; cycle 0 always requests a pixel
        w_pix_nxt   = w_accept || (w_busy_nxt && (w_cyc_nxt < w_wsq));
        w_sl_nxt    = (w_state_nxt == S_FILL) || (w_state_nxt == S_RUN);
        w_mac_nxt   = (w_state_nxt == S_RUN);
        w_lbr_nxt   = (w_state_nxt == S_IDLE) || (w_state_nxt == S_DONE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_err_nxt   = (r_state == S_IDLE) && start && !abort && !w_w_legal;
        w_first_out = w_busy_nxt && !w_accept && (w_cyc_nxt == w_win_first);
        w_flush     = !w_busy_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc             <= '0;
            r_w               <= '0;
            row_length        <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            pix_req           <= 1'b0;
            shifting_filter   <= 1'b0;
            shifting_line     <= 1'b0;
            line_buffer_reset <= 1'b1;
            mac_enable        <= 1'b0;
        end else begin
            r_cyc <= w_cyc_nxt;
            if (w_accept) begin
                r_w        <= img_w;
                // a 3-wide window leaves W-3 entries in each line buffer
                row_length <= img_w - ADDR_FIFO'(3);
            end
            busy              <= w_busy_nxt;
            done              <= w_done_nxt;
            err               <= w_err_nxt;
            pix_req           <= w_pix_nxt;
            shifting_filter   <= w_sf_nxt;
            shifting_line     <= w_sl_nxt;
            line_buffer_reset <= w_lbr_nxt;
            mac_enable        <= w_mac_nxt;
        end
    end

`ifdef CONV_SEQ_PERF_EN
    // Entering DONE from the last DRAIN cycle: done lands on index r_cyc+1,
    // so the frame spans r_cyc+2 cycles. Aborted frames never get here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cycles <= '0;
        end else if (w_done_nxt && (r_state == S_DRAIN)) begin
            frame_cycles <= 32'(r_cyc) + 32'd2;
        end
    end
`endif

    conv_seq_pos_counter #(
        .ADDR_FIFO(ADDR_FIFO)
    ) u_pos (
        .i_clk  (clk),
        .i_rst_n(rst),
        .i_flush(w_flush),
        .i_first(w_first_out),
        .i_w    (r_w),
        .o_valid(out_valid)
    );

    assign dbg_state = r_state;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer
// Directed bench for conv_sequencer. Inputs are driven and outputs sampled
// on the falling clock edge; the cycle index c counts from the first cycle
// after the accepting rising edge.
module tb_conv_sequencer;

    localparam int AW = 10;
    // {dbg_state[2:0], busy, done, err, pix_req, shifting_filter,
    //  shifting_line, line_buffer_reset, mac_enable, out_valid}
    localparam logic [11:0] IDLE_V = 12'h004;
    localparam logic [11:0] ERR_V  = 12'h044;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] img_w = '0;

    logic          busy;
    logic          done;
    logic          err;
    logic          pix_req;
    logic          shifting_filter;
    logic          shifting_line;
    logic          line_buffer_reset;
    logic          mac_enable;
    logic [AW-1:0] row_length;
    logic          out_valid;
    logic [2:0]    dbg_state;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]   frame_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int ov_obs_q[$];

    always #5 clk = ~clk;

    conv_sequencer #(
        .ADDR_FIFO(AW),
        .MAX_W    (512)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .img_w            (img_w),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .pix_req          (pix_req),
        .shifting_filter  (shifting_filter),
        .shifting_line    (shifting_line),
        .line_buffer_reset(line_buffer_reset),
        .mac_enable       (mac_enable),
        .row_length       (row_length),
        .out_valid        (out_valid),
`ifdef CONV_SEQ_PERF_EN
        .frame_cycles     (frame_cycles),
`endif
        .dbg_state        (dbg_state)
    );

    function automatic logic [11:0] obs_vec();
        return {dbg_state, busy, done, err, pix_req, shifting_filter,
                shifting_line, line_buffer_reset, mac_enable, out_valid};
    endfunction

    // Expected outputs on cycle c of a frame of width w
    function automatic logic [11:0] exp_vec(input int w, input int c);
        int         fe, re, de, dn, k;
        logic [2:0] st;
        logic       ov;
        fe = 2 * w + 3;
        re = fe + w * w;
        de = re + 3;
        dn = de + 1;
        if (c <= fe)      st = 3'd1;
        else if (c <= re) st = 3'd2;
        else if (c <= de) st = 3'd3;
        else if (c == dn) st = 3'd4;
        else              st = 3'd0;
        k  = c - (2 * w + 7);
        ov = (c >= 2 * w + 7) && (c <= de) && ((k % w) < (w - 2));
        return {st, c <= de, c == dn, 1'b0, c < w * w, c <= 8, c <= re,
                c >= dn, (c > fe) && (c <= re), ov};
    endfunction

    // Starts a frame from IDLE (caller sits on a falling edge) and checks
    // every cycle. Optional abort / reset / busy-start injection points.
    task automatic run_frame(input int w, input int abort_at, input int rst_at,
                             input int busy_start_at, output int done_cyc,
                             output int pix_cnt, output int ov_cnt,
                             output int mac_first);
        int          last;
        logic [11:0] ev;
        logic [11:0] got;
        last      = 2 * w + 8 + w * w;
        done_cyc  = -1;
        pix_cnt   = 0;
        ov_cnt    = 0;
        mac_first = -1;
        ov_obs_q.delete();
        img_w = AW'(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            ev  = exp_vec(w, c);
            got = obs_vec();
            n_checks++;
            if (got !== ev)
                $display("FAIL frame_w%0d cycle %0d: outputs %b, expected %b", w, c, got, ev);
            else
                n_pass++;
            if (c == 0) begin
                n_checks++;
                if (row_length !== AW'(w - 3))
                    $display("FAIL row_length_w%0d: got %0d, expected %0d", w, row_length, w - 3);
                else
                    n_pass++;
            end
            if (pix_req === 1'b1) pix_cnt++;
            if (out_valid === 1'b1) begin
                ov_cnt++;
                ov_obs_q.push_back(c);
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = c;
            if (mac_enable === 1'b1 && mac_first < 0) mac_first = c;
            if (c == busy_start_at) begin
                start = 1'b1;
                img_w = AW'(5);
            end else if (c == busy_start_at + 1) begin
                start = 1'b0;
                img_w = AW'(w);
            end
            if (c == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                n_checks++;
                if (obs_vec() !== IDLE_V)
                    $display("FAIL abort_w%0d cycle %0d: outputs %b, expected %b",
                             w, c + 1, obs_vec(), IDLE_V);
                else
                    n_pass++;
                break;
            end
            if (c == rst_at) begin
                rst = 1'b0;
                #1;
                n_checks++;
                if (obs_vec() !== IDLE_V || row_length !== '0)
                    $display("FAIL midframe_reset_w%0d: outputs %b row_length %0d, expected %b row_length 0",
                             w, obs_vec(), row_length, IDLE_V);
                else
                    n_pass++;
                @(negedge clk);
                rst = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== IDLE_V || row_length !== '0)
            $display("FAIL reset_values: outputs %b row_length %0d, expected %b row_length 0",
                     obs_vec(), row_length, IDLE_V);
        else
            n_pass++;
`ifdef CONV_SEQ_PERF_EN
        n_checks++;
        if (frame_cycles !== 32'd0)
            $display("FAIL reset_frame_cycles: got %0d, expected 0", frame_cycles);
        else
            n_pass++;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs_vec() !== IDLE_V)
            $display("FAIL idle_after_reset: outputs %b, expected %b", obs_vec(), IDLE_V);
        else
            n_pass++;
    endtask

    task automatic test_frame_w4();
        int d, p, o, m;
        int exp_ov [8];
        exp_ov = '{15, 16, 19, 20, 23, 24, 27, 28};
        run_frame(4, -1, -1, -1, d, p, o, m);
        n_checks++;
        if (d !== 31) $display("FAIL w4_done_cycle: got %0d, expected 31", d); else n_pass++;
        n_checks++;
        if (m !== 12) $display("FAIL w4_mac_first: got %0d, expected 12", m); else n_pass++;
        n_checks++;
        if (p !== 16) $display("FAIL w4_pix_count: got %0d, expected 16", p); else n_pass++;
        n_checks++;
        if (o !== 8 || ov_obs_q.size() !== 8)
            $display("FAIL w4_valid_count: got %0d, expected 8", o);
        else
            n_pass++;
        for (int i = 0; i < 8 && i < ov_obs_q.size(); i++) begin
            n_checks++;
            if (ov_obs_q[i] !== exp_ov[i])
                $display("FAIL w4_valid_cycle[%0d]: got %0d, expected %0d", i, ov_obs_q[i], exp_ov[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_abort();
        int d, p, o, m;
        run_frame(8, 10, -1, -1, d, p, o, m);
        n_checks++;
        if (d !== -1) $display("FAIL abort_no_done: done seen at %0d, expected none", d); else n_pass++;
        @(negedge clk);
        run_frame(8, -1, -1, -1, d, p, o, m);
        n_checks++;
        if (d !== 87) $display("FAIL w8_done_cycle: got %0d, expected 87", d); else n_pass++;
        n_checks++;
        if (p !== 64) $display("FAIL w8_pix_count: got %0d, expected 64", p); else n_pass++;
        n_checks++;
        if (o !== 48) $display("FAIL w8_valid_count: got %0d, expected 48", o); else n_pass++;
        n_checks++;
        if (m !== 20) $display("FAIL w8_mac_first: got %0d, expected 20", m); else n_pass++;
    endtask

    task automatic test_start_abort_same();
        img_w = AW'(8);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs_vec() !== IDLE_V)
                $display("FAIL start_abort_same[%0d]: outputs %b, expected %b", i, obs_vec(), IDLE_V);
            else
                n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_err();
        int bad_w [3];
        bad_w = '{3, 513, 0};
        for (int i = 0; i < 3; i++) begin
            img_w = AW'(bad_w[i]);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (obs_vec() !== ERR_V)
                $display("FAIL err_pulse_w%0d: outputs %b, expected %b", bad_w[i], obs_vec(), ERR_V);
            else
                n_pass++;
            @(negedge clk);
            n_checks++;
            if (obs_vec() !== IDLE_V)
                $display("FAIL err_clear_w%0d: outputs %b, expected %b", bad_w[i], obs_vec(), IDLE_V);
            else
                n_pass++;
        end
    endtask

    task automatic test_max_w();
        int d, p, o, m;
        run_frame(512, 3, -1, -1, d, p, o, m);
        n_checks++;
        if (p !== 4) $display("FAIL w512_pix_count: got %0d, expected 4", p); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_busy_start_and_reset();
        int d, p, o, m;
        run_frame(16, -1, 100, 40, d, p, o, m);
        n_checks++;
        if (d !== -1) $display("FAIL reset_no_done: done seen at %0d, expected none", d); else n_pass++;
        n_checks++;
        if (p !== 101) $display("FAIL w16_pix_count: got %0d, expected 101", p); else n_pass++;
        n_checks++;
        if (m !== 36) $display("FAIL w16_mac_first: got %0d, expected 36", m); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int d, p, o, m;
        run_frame(5, -1, -1, -1, d, p, o, m);
        n_checks++;
        if (d !== 42 || o !== 15)
            $display("FAIL w5_frame: done %0d valid %0d, expected done 42 valid 15", d, o);
        else
            n_pass++;
        run_frame(6, -1, -1, -1, d, p, o, m);
        n_checks++;
        if (d !== 55 || o !== 24 || p !== 36)
            $display("FAIL w6_frame: done %0d valid %0d pix %0d, expected done 55 valid 24 pix 36",
                     d, o, p);
        else
            n_pass++;
    endtask

`ifdef CONV_SEQ_PERF_EN
    task automatic test_perf();
        int d, p, o, m;
        run_frame(4, -1, -1, -1, d, p, o, m);
        n_checks++;
        if (frame_cycles !== 32'd32)
            $display("FAIL perf_w4: got %0d, expected 32", frame_cycles);
        else
            n_pass++;
        run_frame(8, 6, -1, -1, d, p, o, m);
        n_checks++;
        if (frame_cycles !== 32'd32)
            $display("FAIL perf_after_abort: got %0d, expected 32", frame_cycles);
        else
            n_pass++;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_frame_w4();
        test_abort();
        test_start_abort_same();
        test_err();
        test_max_w();
        test_busy_start_and_reset();
        test_back_to_back();
`ifdef CONV_SEQ_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
